mem_burst_ctrl: RTL and testbench
=================================

Name: mem_burst_ctrl

Overview:
- Initiator-side controller for the 16x8 single-port RAM/ROM macro.
- Accepts one burst command (write or read, start address, length) and sequences the macro port: mode, we, addr and din out, dout back.
- Write data arrives on a valid/ready stream; read data leaves on a valid/ready stream with backpressure.
- Sits between the datapath and the memory; the macro's own active-high reset is outside this block's control.

Parameters:
- ADDR_W, 4, memory address width; depth = 2^ADDR_W.
- DATA_W, 8, memory word width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_W  start address.
- cmd_len  in  ADDR_W  burst length minus 1 (0..15 gives 1..16 words).
- wr_data  in  DATA_W  write stream data.
- wr_valid  in  1  write stream valid.
- wr_ready  out  1  write stream ready.
- rd_data  out  DATA_W  read stream data.
- rd_valid  out  1  read stream valid.
- rd_ready  in  1  read stream ready.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a burst completes.
- mem_mode  out  1  drives the macro mode: 1 (RAM) when busy, 0 (ROM, read-only, safe) in IDLE.
- mem_we  out  1  macro write enable; registered.
- mem_addr  out  ADDR_W  macro address; registered.
- mem_din  out  DATA_W  macro write data; registered.
- mem_dout  in  DATA_W  macro registered read data.

Behaviour:
- Reset (reset == 0 at a rising edge):
  - State goes to IDLE and the read FIFO is flushed.
  - Outputs: cmd_ready = 1, wr_ready = 0, rd_valid = 0, rd_data = 0, busy = 0, done = 0, mem_mode = 0, mem_we = 0, mem_addr = 0, mem_din = 0.
  - Reset mid-burst aborts the burst with no done pulse. Memory contents already written stay written.
- States: IDLE, WRITE, READ, DONE.
- IDLE:
  - On command accept, latch addr, len and direction, then go to WRITE or READ.
  - mem_mode = 1 from the next cycle.
- WRITE:
  - wr_ready = 1 while words remain.
  - Each wr_valid && wr_ready registers mem_we = 1, mem_addr = current address and mem_din = wr_data for exactly the next cycle. Otherwise mem_we = 0.
  - Address increments modulo 2^ADDR_W (15 wraps to 0).
  - After the last word is accepted, go to DONE. The last mem_we pulse and the DONE cycle coincide.
- READ:
  - Issue means driving mem_addr = A with mem_we = 0 in cycle C. The macro presents memory[A] on mem_dout during C+1, and the block captures it into the FIFO at the end of C+1.
  - A read is issued only if (FIFO occupancy + reads in flight) < 2. This guarantees no overflow under backpressure.
  - Issue rate is one per cycle while rd_ready is held high. rd_valid rises two cycles after the first issue.
  - Data order equals address order.
  - After all words are issued and the FIFO has drained (last rd_valid && rd_ready), go to DONE.
- DONE:
  - done = 1 and busy = 1 for one cycle, then IDLE.
  - The next command may be accepted in the following cycle.
- Ignored inputs:
  - cmd_valid while busy is ignored; cmd_ready = 0.
  - wr_valid outside WRITE is ignored.
- Stream rules:
  - rd_valid, once high, holds with stable rd_data until rd_ready.
  - wr_valid gaps only stall the burst.

Decomposition:
- Shared package: state enum (IDLE, WRITE, READ, DONE), ADDR_W/DATA_W defaults, and the MEM_MODE_ROM = 0 / MEM_MODE_RAM = 1 constants.
- One sub-module: mem_rd_fifo2, a 2-entry read FIFO with push/pop, count, and flush on reset.

Test Plan:
- Write burst: addr = 2, len = 3, wr_valid held, data A0, A1, A2, A3 -> mem_we high 4 consecutive cycles at mem_addr 2, 3, 4, 5 with matching mem_din. done pulses once in the cycle of the last mem_we. Then a separate read of addr 2..5 returns A0..A3.
- Read burst, no backpressure: addr = 0, len = 7, rd_ready = 1 -> 8 consecutive rd_valid beats of memory[0..7]. First beat 2 cycles after the first issue; done one cycle after the last beat.
- Wrap-around: write addr = 14, len = 3, data 01..04 -> mem_addr 14, 15, 0, 1. Read back from 14 -> 01, 02, 03, 04.
- Backpressure: read len = 15 with rd_ready low for 5 cycles mid-burst -> at most 2 words outstanding, rd_data stable while stalled, all 16 words delivered in order with none lost or duplicated.
- Stalls and ignored command: wr_valid toggling 1, 0, 1, 0 during a write burst -> only accepted beats produce mem_we. A cmd_valid pulse during the burst is not accepted (cmd_ready = 0).
- Reset mid-read: drive reset low after 3 delivered words -> next edge gives all outputs at reset values with no done pulse. A new read command accepted right after reset completes normally.

Source files
------------

// File: rtl/mem_burst_ctrl_pkg.sv
// Shared definitions for the burst controller: FSM states, default widths,
// macro mode encodings and read-buffer depth.
package mem_burst_ctrl_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    localparam logic MEM_MODE_ROM = 1'b0;
    localparam logic MEM_MODE_RAM = 1'b1;

    // Read buffer depth; also the credit limit for reads in flight.
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_burst_ctrl_rd_fifo2.sv
// Two-entry read-data buffer between the macro output and the read stream.
// Active-low synchronous reset flushes contents, pointers and count.
module mem_rd_fifo2
    import mem_burst_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] entry_reg [FIFO_DEPTH];
    logic              wr_ptr_reg;
    logic              rd_ptr_reg;
    logic [1:0]        count_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            entry_reg[0] <= '0;
            entry_reg[1] <= '0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            count_reg    <= 2'd0;
        end else begin
            if (push) begin
                entry_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg            <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign pop_data = entry_reg[rd_ptr_reg];
    assign count    = count_reg;

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst controller for the 16x8 single-port RAM/ROM macro: one write or read
// burst per command, valid/ready streams on both data sides.
module mem_burst_ctrl
    import mem_burst_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done,
    output logic              mem_mode,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t state_reg, state_next;

    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W:0]   words_left_reg;   // words still to accept (write) or issue (read)
    logic [ADDR_W:0]   beats_left_reg;   // read beats still to deliver
    logic              capture_reg;      // mem_dout holds an issued read this cycle
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_din_reg;

    logic              cmd_fire;
    logic              wr_fire;
    logic              rd_pop;
    logic              issue_fire;
    logic              last_delivery;
    logic [2:0]        outstanding;
    logic [1:0]        fifo_count;
    logic [DATA_W-1:0] fifo_data;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign wr_fire  = wr_valid && wr_ready;
    assign rd_valid = (fifo_count != 2'd0);
    assign rd_pop   = rd_valid && rd_ready;

    // mem_addr is presented one cycle ahead of the decision; an address only
    // counts as issued in the cycle its credit check passes, so a refused
    // cycle is just a harmless non-destructive read that gets repeated.
    assign outstanding = {1'b0, fifo_count} - {2'b00, rd_pop} + {2'b00, capture_reg};
    assign issue_fire  = (state_reg == READ) && (words_left_reg != '0) &&
                         (outstanding < 3'(FIFO_DEPTH));

    assign last_delivery = rd_pop && (beats_left_reg == CNT_ONE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        wr_ready   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        mem_mode   = MEM_MODE_RAM;
        case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                mem_mode  = MEM_MODE_ROM;
                if (cmd_valid) begin
                    state_next = cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                wr_ready = 1'b1;
                if (wr_valid && (words_left_reg == CNT_ONE)) begin
                    state_next = DONE;
                end
            end
            READ: begin
                if (last_delivery) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_reg       <= '0;
            words_left_reg <= '0;
            beats_left_reg <= '0;
            capture_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_din_reg    <= '0;
        end else begin
            mem_we_reg  <= wr_fire;
            capture_reg <= issue_fire;
            if (cmd_fire) begin
                addr_reg       <= cmd_addr;
                mem_addr_reg   <= cmd_addr;
                words_left_reg <= {1'b0, cmd_len} + CNT_ONE;
                beats_left_reg <= {1'b0, cmd_len} + CNT_ONE;
            end
            if (wr_fire) begin
                mem_addr_reg   <= addr_reg;
                mem_din_reg    <= wr_data;
                addr_reg       <= addr_reg + ADDR_ONE;
                words_left_reg <= words_left_reg - CNT_ONE;
            end
            if (issue_fire) begin
                mem_addr_reg   <= addr_reg + ADDR_ONE;
                addr_reg       <= addr_reg + ADDR_ONE;
                words_left_reg <= words_left_reg - CNT_ONE;
            end
            if (rd_pop) begin
                beats_left_reg <= beats_left_reg - CNT_ONE;
            end
        end
    end

    mem_rd_fifo2 #(
        .DATA_W (DATA_W)
    ) u_rd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (capture_reg),
        .push_data (mem_dout),
        .pop       (rd_pop),
        .pop_data  (fifo_data),
        .count     (fifo_count)
    );

    assign rd_data  = fifo_data;
    assign mem_we   = mem_we_reg;
    assign mem_addr = mem_addr_reg;
    assign mem_din  = mem_din_reg;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl with a behavioural macro and a
// reference memory image that predicts every write beat and read beat.
module tb_mem_burst_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [3:0] cmd_addr = 4'd0;
    logic [3:0] cmd_len = 4'd0;
    logic [7:0] wr_data = 8'd0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic       busy;
    logic       done;
    logic       mem_mode;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;

    logic [7:0] macro_mem [16];
    logic [7:0] ref_mem [16];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_burst_ctrl #(
        .ADDR_W (4),
        .DATA_W (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .busy      (busy),
        .done      (done),
        .mem_mode  (mem_mode),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    // Behavioural 16x8 macro with registered read data.
    always @(posedge clk) begin
        if (mem_we) macro_mem[mem_addr] <= mem_din;
        mem_dout <= macro_mem[mem_addr];
    end

    function automatic logic [3:0] wrap(logic [3:0] a, int i);
        return 4'(int'(a) + i);
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, ".wr_ready"},  32'(wr_ready),  32'd0);
        check({tag, ".rd_valid"},  32'(rd_valid),  32'd0);
        check({tag, ".rd_data"},   32'(rd_data),   32'd0);
        check({tag, ".busy"},      32'(busy),      32'd0);
        check({tag, ".done"},      32'(done),      32'd0);
        check({tag, ".mem_mode"},  32'(mem_mode),  32'd0);
        check({tag, ".mem_we"},    32'(mem_we),    32'd0);
        check({tag, ".mem_addr"},  32'(mem_addr),  32'd0);
        check({tag, ".mem_din"},   32'(mem_din),   32'd0);
    endtask

    task automatic do_cmd(logic w, logic [3:0] a, logic [3:0] l);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        check("mem_mode_after_accept", 32'(mem_mode), 32'd1);
    endtask

    // base < 0 selects random data, otherwise data[i] = base + i.
    task automatic write_burst(logic [3:0] a, logic [3:0] l, int base, bit gap, bit poke);
        logic [7:0] data [16];
        int   n;
        int   idx;
        int   cyc;
        logic acc;
        logic tog;
        n   = int'(l) + 1;
        idx = 0;
        cyc = 0;
        tog = 1'b1;
        for (int i = 0; i < 16; i++) data[i] = (base < 0) ? 8'($urandom) : 8'(base + i);
        do_cmd(1'b1, a, l);
        while (idx < n && cyc < 200) begin
            wr_valid = gap ? tog : 1'b1;
            tog      = ~tog;
            wr_data  = data[idx];
            check("wr_ready_in_write", 32'(wr_ready), 32'd1);
            if (poke && cyc == 1) begin
                cmd_valid = 1'b1;
                check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
            end
            acc = wr_valid && wr_ready;
            tick();
            cyc++;
            cmd_valid = 1'b0;
            if (acc) idx++;
            check("wr_mem_we", 32'(mem_we), 32'(acc));
            if (acc) begin
                check("wr_mem_addr", 32'(mem_addr), 32'(wrap(a, idx - 1)));
                check("wr_mem_din", 32'(mem_din), 32'(data[idx - 1]));
                ref_mem[wrap(a, idx - 1)] = data[idx - 1];
            end
            check("wr_done", 32'(done), 32'(acc && idx == n));
        end
        check("wr_words_accepted", 32'(idx), 32'(n));
        $display("[TB] write addr=%0d len=%0d words=%0d cycles=%0d", a, l, idx, cyc);
        // wr_valid stays high through DONE and must be ignored
        tick();
        check("wr_after_mem_we", 32'(mem_we), 32'd0);
        check("wr_after_done", 32'(done), 32'd0);
        check("wr_after_busy", 32'(busy), 32'd0);
        check("wr_after_mem_mode", 32'(mem_mode), 32'd0);
        wr_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: 5-cycle stall window, 2: random ready.
    task automatic read_burst(logic [3:0] a, logic [3:0] l, int mode, int rst_after);
        int         n;
        int         got;
        int         cyc;
        int         first_cyc;
        int         last_cyc;
        logic       pend;
        logic [7:0] pend_data;
        logic       rdy;
        n         = int'(l) + 1;
        got       = 0;
        first_cyc = -1;
        last_cyc  = -1;
        pend      = 1'b0;
        pend_data = 8'd0;
        do_cmd(1'b0, a, l);
        cyc = 1;
        while (got < n && cyc < 300) begin
            if (pend) begin
                check("rd_hold_valid", 32'(rd_valid), 32'd1);
                check("rd_hold_data", 32'(rd_data), 32'(pend_data));
            end
            check("rd_no_early_done", 32'(done), 32'd0);
            check("rd_mem_we_low", 32'(mem_we), 32'd0);
            if (rd_valid && first_cyc < 0) first_cyc = cyc;
            if (rd_valid) check("rd_data", 32'(rd_data), 32'(ref_mem[wrap(a, got)]));
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = !(cyc >= 6 && cyc < 11);
            else                rdy = ($urandom_range(0, 2) != 0);
            rd_ready  = rdy;
            pend      = rd_valid && !rdy;
            pend_data = rd_data;
            if (rd_valid && rdy) begin
                got++;
                last_cyc = cyc;
            end
            tick();
            cyc++;
            if (rst_after > 0 && got == rst_after) begin
                reset = 1'b0;
                rd_ready = 1'b0;
                tick();
                check_reset_vals("rst_mid_read");
                reset = 1'b1;
                $display("[TB] read addr=%0d len=%0d aborted by reset after %0d words", a, l, got);
                return;
            end
        end
        check("rd_words_delivered", 32'(got), 32'(n));
        check("rd_first_latency", 32'(first_cyc), 32'd3);
        if (mode == 0) check("rd_last_beat_cycle", 32'(last_cyc), 32'(3 + int'(l)));
        check("rd_done_pulse", 32'(done), 32'd1);
        check("rd_done_busy", 32'(busy), 32'd1);
        rd_ready = 1'b0;
        $display("[TB] read addr=%0d len=%0d mode=%0d words=%0d last_beat_cycle=%0d", a, l, mode, got, last_cyc);
        tick();
        check("rd_after_done", 32'(done), 32'd0);
        check("rd_after_busy", 32'(busy), 32'd0);
        check("rd_after_rd_valid", 32'(rd_valid), 32'd0);
    endtask

    initial begin
        logic [3:0] ra;
        logic [3:0] rl;

        reset = 1'b0;
        tick();
        tick();
        check_reset_vals("reset");
        $display("[TB] reset checked");
        reset = 1'b1;
        tick();

        write_burst(4'd2, 4'd3, 'hA0, 1'b0, 1'b0);
        read_burst(4'd2, 4'd3, 0, 0);

        write_burst(4'd0, 4'd15, -1, 1'b0, 1'b0);
        read_burst(4'd0, 4'd7, 0, 0);

        write_burst(4'd14, 4'd3, 1, 1'b0, 1'b0);
        read_burst(4'd14, 4'd3, 0, 0);

        read_burst(4'd0, 4'd15, 1, 0);

        write_burst(4'd5, 4'd5, -1, 1'b1, 1'b1);
        read_burst(4'd5, 4'd5, 2, 0);

        for (int k = 0; k < 8; k++) begin
            ra = 4'($urandom_range(0, 15));
            rl = 4'($urandom_range(0, 15));
            write_burst(ra, rl, -1, ($urandom_range(0, 1) == 1), (rl >= 4'd2) && (k % 2 == 1));
            ra = 4'($urandom_range(0, 15));
            rl = 4'($urandom_range(0, 15));
            read_burst(ra, rl, 2, 0);
        end

        read_burst(4'd3, 4'd15, 0, 3);
        tick();
        read_burst(4'd9, 4'd4, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
